// File: rtl/wb_sdram_arbiter_if.sv
// Bus bundle between the two Wishbone requesters, the arbiter and the SDRAM controller's slave port.
// The slave modport is the arbiter's view; the master modport is the requester/SDRAM side.
interface wb_sdram_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic [1:0]          m_cyc_i;
  logic [1:0]          m_stb_i;
  logic [1:0]          m_we_i;
  logic [2*AW-1:0]     m_addr_i;
  logic [2*DW-1:0]     m_dat_i;
  logic [2*(DW/8)-1:0] m_sel_i;
  logic [5:0]          m_cti_i;
  logic [DW-1:0]       m_dat_o;
  logic [1:0]          m_ack_o;
  logic [1:0]          m_err_o;
  logic                s_cyc_o;
  logic                s_stb_o;
  logic                s_we_o;
  logic [AW-1:0]       s_addr_o;
  logic [DW-1:0]       s_dat_o;
  logic [DW/8-1:0]     s_sel_o;
  logic [2:0]          s_cti_o;
  logic [DW-1:0]       s_dat_i;
  logic                s_ack_i;
  logic [1:0]          gnt_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
    output gnt_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o,
    input  gnt_o
  );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Round-robin two-requester Wishbone arbiter for the SDRAM controller slave port.
// Grants are cyc-framed, gated on sdr_init_done, and a per-transfer watchdog kicks out stalled owners.
module wb_sdram_arbiter #(
  parameter int DW  = 32,
  parameter int AW  = 26,
  parameter int TMO = 256
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  input logic               sdr_init_done,
  wb_sdram_arbiter_if.slave bus
);

  localparam int SW = DW / 8;
  localparam int TW = $clog2(TMO) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TMO - 1);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic own;
  logic idx;
  logic own_cyc;
  logic own_stb;
  logic timeout;

  assign own       = (state_q == GNT0) || (state_q == GNT1);
  assign idx       = (state_q == GNT1);
  assign own_cyc   = own && bus.m_cyc_i[idx];
  assign own_stb   = own && bus.m_stb_i[idx];
  assign timeout   = own_cyc && own_stb && !bus.s_ack_i && (tcnt_q == TLAST);
  assign bus.gnt_o = state_q;
  assign bus.m_dat_o = bus.s_dat_i;

  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_addr_o = '0;
    bus.s_dat_o  = '0;
    bus.s_sel_o  = '0;
    bus.s_cti_o  = '0;
    bus.m_ack_o  = 2'b00;
    bus.m_err_o  = 2'b00;
    if (own) begin
      bus.s_cyc_o  = own_cyc;
      bus.s_stb_o  = own_stb;
      bus.s_we_o   = bus.m_we_i[idx];
      bus.s_addr_o = idx ? bus.m_addr_i[AW +: AW] : bus.m_addr_i[0 +: AW];
      bus.s_dat_o  = idx ? bus.m_dat_i[DW +: DW]  : bus.m_dat_i[0 +: DW];
      bus.s_sel_o  = idx ? bus.m_sel_i[SW +: SW]  : bus.m_sel_i[0 +: SW];
      bus.s_cti_o  = idx ? bus.m_cti_i[5:3]       : bus.m_cti_i[2:0];
      bus.m_ack_o  = idx ? {bus.s_ack_i, 1'b0}    : {1'b0, bus.s_ack_i};
      bus.m_err_o  = idx ? {timeout, 1'b0}        : {1'b0, timeout};
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (sdr_init_done) begin
          if (bus.m_cyc_i == 2'b11) begin
            state_d = last_q ? GNT0 : GNT1;
          end else if (bus.m_cyc_i[0]) begin
            state_d = GNT0;
          end else if (bus.m_cyc_i[1]) begin
            state_d = GNT1;
          end
        end
      end
      GNT0, GNT1: begin
        if (!bus.m_cyc_i[idx]) begin
          // Owner released: hand straight over if the other side is waiting.
          last_d  = idx;
          tcnt_d  = '0;
          state_d = (bus.m_cyc_i[~idx] && sdr_init_done) ? (idx ? GNT0 : GNT1) : IDLE;
        end else if (timeout) begin
          last_d  = idx;
          tcnt_d  = '0;
          state_d = IDLE;
        end else if (own_stb && !bus.s_ack_i) begin
          tcnt_d = tcnt_q + TW'(1);
        end else begin
          tcnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule
